// File: rtl/bdc_sync_if.sv
// BDC SYNC engine bundle: sequencer handshake, BKGD pad pins and measured result.
interface bdc_sync_if;
  logic        start;
  logic        bkgd_in;
  logic        bkgd_oe;
  logic        bkgd_out;
  logic        busy;
  logic [31:0] sync_length;
  logic        set_sync_length;
  logic        err_timeout;
  logic        err_range;

  modport master (
    output start, bkgd_in,
    input  bkgd_oe, bkgd_out, busy, sync_length, set_sync_length, err_timeout, err_range
  );

  modport slave (
    input  start, bkgd_in,
    output bkgd_oe, bkgd_out, busy, sync_length, set_sync_length, err_timeout, err_range
  );
endinterface

// File: rtl/bdc_sync_measure.sv
// Host-side BDC SYNC: drives the request pulse on BKGD, then times the target's
// low response in clk cycles (bit period as count/128 fixed point).
module bdc_sync_measure #(
  parameter int unsigned REQ_LOW_CYCLES = 20000,
  parameter int unsigned SPEEDUP_CYCLES = 4,
  parameter int unsigned WAIT_TIMEOUT   = 65535,
  parameter int unsigned MIN_LOW_CYCLES = 128,
  parameter int unsigned MAX_LOW_CYCLES = 32'h00FF_FFFF
) (
  input logic        clk,
  input logic        rst,
  bdc_sync_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_LOW,
    S_SPEEDUP,
    S_WAIT_FALL,
    S_MEASURE,
    S_DONE
  } state_t;

  localparam logic [31:0] REQ_LAST = 32'(REQ_LOW_CYCLES - 1);
  localparam logic [31:0] SPD_LAST = 32'(SPEEDUP_CYCLES - 1);
  localparam logic [31:0] TMO_LAST = 32'(WAIT_TIMEOUT - 1);
  localparam logic [31:0] MIN_LOW  = 32'(MIN_LOW_CYCLES);
  localparam logic [31:0] MAX_LOW  = 32'(MAX_LOW_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] len_q, len_d;
  logic        set_q, set_d;
  logic        tmo_q, tmo_d;
  logic        rng_q, rng_d;
  logic [1:0]  sync_q;
  logic        bs;

  // Both edges see the same 2-cycle synchronizer delay, so it drops out of the count.
  assign bs = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      set_q   <= 1'b0;
      tmo_q   <= 1'b0;
      rng_q   <= 1'b0;
      sync_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      set_q   <= set_d;
      tmo_q   <= tmo_d;
      rng_q   <= rng_d;
      sync_q  <= {sync_q[0], bus.bkgd_in};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    len_d   = len_q;
    set_d   = 1'b0;
    tmo_d   = 1'b0;
    rng_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.start) state_d = S_REQ_LOW;
      end
      S_REQ_LOW: begin
        if (cnt_q == REQ_LAST) begin
          state_d = S_SPEEDUP;
          cnt_d   = '0;
        end
      end
      S_SPEEDUP: begin
        if (cnt_q == SPD_LAST) begin
          state_d = S_WAIT_FALL;
          cnt_d   = '0;
        end
      end
      S_WAIT_FALL: begin
        // A low sample on the last allowed cycle still counts as the response.
        if (!bs) begin
          state_d = S_MEASURE;
          cnt_d   = 32'd1;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end
      end
      S_MEASURE: begin
        if (bs) begin
          state_d = S_DONE;
          cnt_d   = '0;
          if (cnt_q < MIN_LOW) begin
            rng_d = 1'b1;
          end else begin
            set_d = 1'b1;
            len_d = cnt_q;
          end
        end else if (cnt_q >= MAX_LOW) begin
          state_d = S_DONE;
          cnt_d   = '0;
          rng_d   = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.bkgd_oe         = (state_q == S_REQ_LOW) || (state_q == S_SPEEDUP);
  assign bus.bkgd_out        = (state_q != S_REQ_LOW);
  assign bus.busy            = (state_q != S_IDLE);
  assign bus.sync_length     = len_q;
  assign bus.set_sync_length = set_q;
  assign bus.err_timeout     = tmo_q;
  assign bus.err_range       = rng_q;

endmodule
